// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared constants and IF/ID record for the ARM pipeline
// Purpose: default reset PC, the NOP word injected on squash, and the IF/ID
//          pipeline register layout used by fetch and decode.
package arm_pipe_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;  // MOV R0,R0

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// rtl/pipe_reg_en_clr.sv - generic pipeline register with enable and clear
// Purpose: holds one pipeline record. Priority reset > clr > en > hold.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset, loads RESET_VAL
//   en     in  load d
//   clr    in  squash: bits selected by CLR_KEEP hold, all others take CLR_VAL
//   d      in  next record
//   q      out registered record
module pipe_reg_en_clr #(
  parameter type T         = logic [31:0],
  parameter T    RESET_VAL = '0,
  parameter T    CLR_VAL   = '0,
  parameter T    CLR_KEEP  = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= T'((q & CLR_KEEP) | (CLR_VAL & ~CLR_KEEP));
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, next-PC mux and IF/ID register
// Purpose: drives the instruction-memory address, captures the returned word
//          into IF/ID, and honours stall/flush and EX branch redirect.
// Optional feature: FETCH_STATS_EN adds saturating fetch_cnt / bubble_cnt.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stall_f           hold PC
//   stall_d           hold IF/ID
//   flush_d           squash IF/ID to NOP
//   branch_taken_e    redirect from EX this cycle
//   branch_target_e   redirect target (bits [1:0] ignored)
//   pc_f              fetch address to instruction memory
//   instr_f           instruction word for pc_f (combinational memory)
//   instr_d, pc_d, pc_plus8_d, valid_d   IF/ID outputs
//   fetch_cnt, bubble_cnt                (FETCH_STATS_EN only)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = arm_pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = arm_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_taken_e,
  input  logic [31:0] branch_target_e,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus8_d,
  output logic        valid_d
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);
  import arm_pipe_pkg::*;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  localparam if_id_t IFID_RESET = '{instr: NOP_INSTR, pc: 32'h0,
                                    pc_plus8: 32'h8, valid: 1'b0};
  localparam if_id_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0,
                                     pc_plus8: 32'h0, valid: 1'b0};
  // A squash replaces the instruction and valid bit but keeps the PC fields.
  localparam if_id_t IFID_KEEP = '{instr: 32'h0, pc: 32'hFFFF_FFFF,
                                   pc_plus8: 32'hFFFF_FFFF, valid: 1'b0};

  logic [31:0] pc_q;
  logic [31:0] target_aligned;
  logic        squash;
  logic        load;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  // Masking instead of slicing keeps every target bit in use.
  assign target_aligned = branch_target_e & WORD_MASK;
  assign pc_f           = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC & WORD_MASK;
    end else if (branch_taken_e) begin
      pc_q <= target_aligned;       // redirect beats stall_f
    end else if (!stall_f) begin
      pc_q <= pc_q + 32'd4;         // wraps modulo 2^32
    end
  end

  // The instruction in IF when a branch resolves is on the wrong path.
  assign squash = flush_d | branch_taken_e;
  assign load   = !squash && !stall_d;

  assign if_id_d = '{instr: instr_f, pc: pc_q, pc_plus8: pc_q + 32'd8, valid: 1'b1};

  pipe_reg_en_clr #(
    .T         (if_id_t),
    .RESET_VAL (IFID_RESET),
    .CLR_VAL   (IFID_BUBBLE),
    .CLR_KEEP  (IFID_KEEP)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .en    (!stall_d),
    .clr   (squash),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign instr_d    = if_id_q.instr;
  assign pc_d       = if_id_q.pc;
  assign pc_plus8_d = if_id_q.pc_plus8;
  assign valid_d    = if_id_q.valid;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (load && fetch_cnt != 32'hFFFF_FFFF) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (squash && bubble_cnt != 32'hFFFF_FFFF) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus8_d;
  logic        valid_d;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address a is 32'hEA00_0000 + a.
  assign instr_f = 32'hEA00_0000 + pc_f;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .branch_taken_e  (branch_taken_e),
    .branch_target_e (branch_target_e),
    .pc_f            (pc_f),
    .instr_f         (instr_f),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus8_d      (pc_plus8_d),
    .valid_d         (valid_d)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .bubble_cnt      (bubble_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    branch_taken_e = 1'b0; branch_target_e = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_pc_f got=%h exp=%h", pc_f, 32'h0); end
    checks++; if (instr_d !== 32'hE1A00000) begin errors++; $display("FAIL reset_instr_d got=%h exp=%h", instr_d, 32'hE1A00000); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL reset_pc_d got=%h exp=%h", pc_d, 32'h0); end
    checks++; if (pc_plus8_d !== 32'h8) begin errors++; $display("FAIL reset_pc_plus8_d got=%h exp=%h", pc_plus8_d, 32'h8); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid_d got=%b exp=0", valid_d); end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pc_f !== exp_pc[i]) begin errors++; $display("FAIL run_pc_f[%0d] got=%h exp=%h", i, pc_f, exp_pc[i]); end
      checks++; if (pc_d !== exp_pc[i] - 32'h4) begin errors++; $display("FAIL run_pc_d[%0d] got=%h exp=%h", i, pc_d, exp_pc[i] - 32'h4); end
      checks++; if (instr_d !== 32'hEA000000 + exp_pc[i] - 32'h4) begin errors++; $display("FAIL run_instr_d[%0d] got=%h", i, instr_d); end
      checks++; if (pc_plus8_d !== exp_pc[i] + 32'h4) begin errors++; $display("FAIL run_pc_plus8_d[%0d] got=%h exp=%h", i, pc_plus8_d, exp_pc[i] + 32'h4); end
      checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL run_valid_d[%0d] got=%b exp=1", i, valid_d); end
    end
  endtask

  task automatic test_stall();
    stall_f = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_f !== 32'h10) begin errors++; $display("FAIL stall_pc_f[%0d] got=%h exp=%h", i, pc_f, 32'h10); end
      checks++; if (instr_d !== 32'hEA00000C) begin errors++; $display("FAIL stall_instr_d[%0d] got=%h exp=%h", i, instr_d, 32'hEA00000C); end
      checks++; if (pc_d !== 32'hC) begin errors++; $display("FAIL stall_pc_d[%0d] got=%h exp=%h", i, pc_d, 32'hC); end
    end
    idle_inputs();
    step();
    checks++; if (pc_f !== 32'h14) begin errors++; $display("FAIL release_pc_f got=%h exp=%h", pc_f, 32'h14); end
    checks++; if (instr_d !== 32'hEA000010) begin errors++; $display("FAIL release_instr_d got=%h exp=%h", instr_d, 32'hEA000010); end
  endtask

  task automatic test_branch();
    step(); step(); step();  // pc_f 0x18, 0x1C, 0x20
    checks++; if (pc_f !== 32'h20) begin errors++; $display("FAIL pre_branch_pc_f got=%h exp=%h", pc_f, 32'h20); end
    branch_taken_e = 1'b1; branch_target_e = 32'h43;
    step();
    checks++; if (pc_f !== 32'h40) begin errors++; $display("FAIL branch_pc_f got=%h exp=%h", pc_f, 32'h40); end
    checks++; if (instr_d !== 32'hE1A00000) begin errors++; $display("FAIL branch_instr_d got=%h exp=%h", instr_d, 32'hE1A00000); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL branch_valid_d got=%b exp=0", valid_d); end
    checks++; if (pc_d !== 32'h1C) begin errors++; $display("FAIL branch_pc_d_hold got=%h exp=%h", pc_d, 32'h1C); end
    checks++; if (pc_plus8_d !== 32'h24) begin errors++; $display("FAIL branch_pc_plus8_hold got=%h exp=%h", pc_plus8_d, 32'h24); end
    idle_inputs();
    step();
    checks++; if (instr_d !== 32'hEA000040) begin errors++; $display("FAIL post_branch_instr_d got=%h exp=%h", instr_d, 32'hEA000040); end
    checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL post_branch_valid_d got=%b exp=1", valid_d); end
  endtask

  task automatic test_flush_beats_stall();
    // pc_f = 0x44, pc_d = 0x40 here
    branch_taken_e = 1'b1; branch_target_e = 32'h80; stall_f = 1'b1; stall_d = 1'b1;
    step();
    checks++; if (pc_f !== 32'h80) begin errors++; $display("FAIL redir_stall_pc_f got=%h exp=%h", pc_f, 32'h80); end
    checks++; if (instr_d !== 32'hE1A00000) begin errors++; $display("FAIL redir_stall_instr_d got=%h exp=%h", instr_d, 32'hE1A00000); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL redir_stall_valid_d got=%b exp=0", valid_d); end
    checks++; if (pc_d !== 32'h40) begin errors++; $display("FAIL redir_stall_pc_d got=%h exp=%h", pc_d, 32'h40); end
    idle_inputs();
    step();
    checks++; if (instr_d !== 32'hEA000080) begin errors++; $display("FAIL redir_resume_instr_d got=%h exp=%h", instr_d, 32'hEA000080); end
    flush_d = 1'b1; stall_d = 1'b1; stall_f = 1'b1;
    step();
    checks++; if (pc_f !== 32'h84) begin errors++; $display("FAIL flush_stall_pc_f got=%h exp=%h", pc_f, 32'h84); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL flush_stall_valid_d got=%b exp=0", valid_d); end
    checks++; if (instr_d !== 32'hE1A00000) begin errors++; $display("FAIL flush_stall_instr_d got=%h exp=%h", instr_d, 32'hE1A00000); end
    checks++; if (pc_d !== 32'h80) begin errors++; $display("FAIL flush_stall_pc_d got=%h exp=%h", pc_d, 32'h80); end
    idle_inputs();
  endtask

  task automatic test_wrap_and_reset();
    branch_taken_e = 1'b1; branch_target_e = 32'hFFFF_FFFF;
    step();
    checks++; if (pc_f !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target_pc_f got=%h exp=%h", pc_f, 32'hFFFFFFFC); end
    idle_inputs();
    step();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL wrap_pc_f got=%h exp=%h", pc_f, 32'h0); end
    checks++; if (pc_d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_d got=%h exp=%h", pc_d, 32'hFFFFFFFC); end
    checks++; if (pc_plus8_d !== 32'h4) begin errors++; $display("FAIL wrap_pc_plus8_d got=%h exp=%h", pc_plus8_d, 32'h4); end
    checks++; if (instr_d !== 32'hE9FF_FFFC) begin errors++; $display("FAIL wrap_instr_d got=%h exp=%h", instr_d, 32'hE9FFFFFC); end
    step();  // pc_f = 4
    stall_f = 1'b1; stall_d = 1'b1;
    step();
    reset = 1'b1;
    step();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL midreset_pc_f got=%h exp=%h", pc_f, 32'h0); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL midreset_valid_d got=%b exp=0", valid_d); end
    checks++; if (pc_plus8_d !== 32'h8) begin errors++; $display("FAIL midreset_pc_plus8_d got=%h exp=%h", pc_plus8_d, 32'h8); end
    reset = 1'b0;
    idle_inputs();
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    step();
    checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL stats_reset_fetch got=%0d exp=0", fetch_cnt); end
    checks++; if (bubble_cnt !== 32'h0) begin errors++; $display("FAIL stats_reset_bubble got=%0d exp=0", bubble_cnt); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    flush_d = 1'b1;
    step(); step();
    flush_d = 1'b0;
    checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL stats_fetch got=%0d exp=5", fetch_cnt); end
    checks++; if (bubble_cnt !== 32'd2) begin errors++; $display("FAIL stats_bubble got=%0d exp=2", bubble_cnt); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL stats_rezero_fetch got=%0d exp=0", fetch_cnt); end
    checks++; if (bubble_cnt !== 32'h0) begin errors++; $display("FAIL stats_rezero_bubble got=%0d exp=0", bubble_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_flush_beats_stall();
    test_wrap_and_reset();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
